// File: rtl/big_core_dmem_arb.sv
// rtl/big_core_dmem_arb.sv - round-robin D_MEM arbiter with per-master read-response tag pipeline
// Optional: define BIG_CORE_DMEM_ARB_PRIO_EN to give master 0 fixed highest priority.
module big_core_dmem_arb #(
    parameter int NUM_MSTR = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic [NUM_MSTR-1:0][DATA_W-1:0]    MstrWrData,
    input  logic [NUM_MSTR-1:0][ADDR_W-1:0]    MstrAddress,
    input  logic [NUM_MSTR-1:0][DATA_W/8-1:0]  MstrByteEn,
    input  logic [NUM_MSTR-1:0]                MstrWrEn,
    input  logic [NUM_MSTR-1:0]                MstrRdEn,
    output logic [NUM_MSTR-1:0]                MstrGnt,
    output logic [DATA_W-1:0]                  MstrRdRsp,
    output logic [NUM_MSTR-1:0]                MstrRdRspVld,
    output logic [DATA_W-1:0]                  DMemWrDataQ103H,
    output logic [ADDR_W-1:0]                  DMemAddressQ103H,
    output logic [DATA_W/8-1:0]                DMemByteEnQ103H,
    output logic                               DMemWrEnQ103H,
    output logic                               DMemRdEnQ103H,
    input  logic [DATA_W-1:0]                  DMemRdRspQ104H
);
    localparam int IDX_W = $clog2(NUM_MSTR);

    logic [NUM_MSTR-1:0]             req;
    logic [IDX_W-1:0]                last_gnt;
    logic [IDX_W-1:0]                gnt_idx;
    logic                            gnt_vld;
    logic [IDX_W:0]                  cand;
    logic [IDX_W-1:0]                rd_idx_q;
    logic [RD_LAT-1:0]               tag_vld;
    logic [RD_LAT-1:0][IDX_W-1:0]    tag_idx;

    assign req = MstrWrEn | MstrRdEn;

    // cand is one bit wider than an index so last_gnt + k never overflows before the wrap.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
`ifdef BIG_CORE_DMEM_ARB_PRIO_EN
        if (req[0]) begin
            gnt_vld = 1'b1;
        end else begin
            for (int k = 1; k < NUM_MSTR; k++) begin
                cand = {1'b0, last_gnt} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_MSTR)) begin
                    cand = cand - (IDX_W+1)'(NUM_MSTR - 1);
                end
                if (!gnt_vld && req[cand[IDX_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[IDX_W-1:0];
                end
            end
        end
`else
        for (int k = 1; k <= NUM_MSTR; k++) begin
            cand = {1'b0, last_gnt} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_MSTR)) begin
                cand = cand - (IDX_W+1)'(NUM_MSTR);
            end
            if (!gnt_vld && req[cand[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
`endif
    end

    assign MstrGnt = (gnt_vld && Rst) ? (NUM_MSTR'(1) << gnt_idx) : '0;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_gnt         <= IDX_W'(NUM_MSTR - 1);
            rd_idx_q         <= '0;
            DMemWrDataQ103H  <= '0;
            DMemAddressQ103H <= '0;
            DMemByteEnQ103H  <= '0;
            DMemWrEnQ103H    <= 1'b0;
            DMemRdEnQ103H    <= 1'b0;
        end else begin
            DMemWrEnQ103H <= 1'b0;
            DMemRdEnQ103H <= 1'b0;
            if (gnt_vld) begin
`ifdef BIG_CORE_DMEM_ARB_PRIO_EN
                if (gnt_idx != '0) begin
                    last_gnt <= gnt_idx;
                end
`else
                last_gnt <= gnt_idx;
`endif
                rd_idx_q         <= gnt_idx;
                DMemWrDataQ103H  <= MstrWrData[gnt_idx];
                DMemAddressQ103H <= MstrAddress[gnt_idx];
                DMemByteEnQ103H  <= MstrByteEn[gnt_idx];
                DMemWrEnQ103H    <= MstrWrEn[gnt_idx];
                // A write-and-read request is treated as a write only.
                DMemRdEnQ103H    <= MstrRdEn[gnt_idx] & ~MstrWrEn[gnt_idx];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tag_vld <= '0;
            tag_idx <= '0;
        end else begin
            tag_vld[0] <= DMemRdEnQ103H;
            tag_idx[0] <= rd_idx_q;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    assign MstrRdRspVld = tag_vld[RD_LAT-1] ? (NUM_MSTR'(1) << tag_idx[RD_LAT-1]) : '0;
    assign MstrRdRsp    = tag_vld[RD_LAT-1] ? DMemRdRspQ104H : '0;

`ifndef SYNTHESIS
    wr_rd_both_granted: assert property (@(posedge Clk) disable iff (!Rst)
        !(gnt_vld && MstrWrEn[gnt_idx] && MstrRdEn[gnt_idx]));
`endif

endmodule
